// File: rtl/count_sequence_monitor_pkg.sv
// Shared types for the count sequence monitor.
// FSM state encoding and step classes.
package count_sequence_monitor_pkg;

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_BAD  = 2'd3
  } step_e;

  localparam int RUN_W = 4;

  function automatic logic is_move(step_e s);
    return (s == STEP_INC) || (s == STEP_DEC);
  endfunction

endpackage

// File: rtl/count_sequence_monitor_if.sv
// Observed counter bus plus recovered status.
// master drives CLR/Q, slave is the monitor.
interface count_sequence_monitor_if #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
);

  logic              CLR;
  logic [WIDTH-1:0]  Q;
  logic              DIR;
  logic              LOCK;
  logic              HELD;
  logic              ERR;
  logic [WRAP_W-1:0] WRAPS;

  modport master (
    output CLR,
    output Q,
    input  DIR,
    input  LOCK,
    input  HELD,
    input  ERR,
    input  WRAPS
  );

  modport slave (
    input  CLR,
    input  Q,
    output DIR,
    output LOCK,
    output HELD,
    output ERR,
    output WRAPS
  );

endinterface

// File: rtl/count_sequence_monitor_step_classifier.sv
// Classifies one counter step from prev to q,
// modulo 2^WIDTH.
module count_sequence_monitor_step_classifier
  import count_sequence_monitor_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] q,
  output step_e            step
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] delta;

  always_comb begin
    delta = q - prev;
    step  = STEP_BAD;
    unique case (1'b1)
      (delta == '0):  step = STEP_HOLD;
      (delta == ONE): step = STEP_INC;
      (delta == '1):  step = STEP_DEC;
      default:        step = STEP_BAD;
    endcase
  end

endmodule

// File: rtl/count_sequence_monitor.sv
// Checker for a WIDTH-bit up/down counter bus:
// recovers direction/hold, locks, faults, counts wraps.
module count_sequence_monitor
  import count_sequence_monitor_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 3,
  parameter int WRAP_W     = 8
) (
  input  logic                    C,
  input  logic                    R,
  count_sequence_monitor_if.slave bus
);

  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_STEPS);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               dir_q, dir_d;
  logic               held_q, held_d;
  logic               lock_q, lock_d;
  logic               err_q, err_d;
  logic [WRAP_W-1:0]  wraps_q, wraps_d;

  step_e              step;
  logic               mv;
  logic               mv_dec;
  logic               hold;
  logic               wrap;
  logic               wrap_en;
  logic [RUN_W-1:0]   run_inc;

  count_sequence_monitor_step_classifier #(
    .WIDTH (WIDTH)
  ) u_cls (
    .prev (prev_q),
    .q    (bus.Q),
    .step (step)
  );

  assign mv     = is_move(step);
  assign mv_dec = (step == STEP_DEC);
  assign hold   = (step == STEP_HOLD);
  assign wrap   = ((step == STEP_INC) && (prev_q == '1))
               || ((step == STEP_DEC) && (prev_q == '0));
  assign run_inc = (run_q >= RUN_MAX) ? RUN_MAX
                                      : run_q + RUN_ONE;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    dir_d   = dir_q;
    held_d  = held_q;
    wraps_d = wraps_q;
    wrap_en = 1'b0;
    if (bus.CLR) begin
      state_d = ST_ACQ;
      run_d   = '0;
      held_d  = 1'b0;
    end else begin
      prev_d = bus.Q;
      unique case (state_q)
        ST_ACQ: begin
          state_d = ST_SYNC;
          run_d   = '0;
        end
        ST_SYNC: begin
          held_d = hold;
          if (step == STEP_BAD) begin
            run_d = '0;
          end else if (mv) begin
            // an opposite step restarts the run in the new direction
            if (run_q == '0 || mv_dec == dir_q) begin
              run_d = run_inc;
            end else begin
              run_d = RUN_ONE;
            end
            dir_d = mv_dec;
            if (run_d == RUN_MAX) begin
              state_d = ST_LOCKED;
              wrap_en = 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          held_d = hold;
          if (step == STEP_BAD) begin
            state_d = ST_FAULT;
          end else if (mv) begin
            // reversal is legal only straight after a hold
            if (mv_dec == dir_q || held_q) begin
              dir_d   = mv_dec;
              wrap_en = 1'b1;
            end else begin
              state_d = ST_FAULT;
            end
          end
        end
        default: begin
          held_d = hold;
        end
      endcase
      if (wrap_en && wrap && wraps_q != '1) begin
        wraps_d = wraps_q + WRAP_W'(1);
      end
    end
  end

  assign lock_d = (state_d == ST_LOCKED);
  assign err_d  = (state_d == ST_FAULT);

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= ST_ACQ;
      prev_q  <= '0;
      run_q   <= '0;
      dir_q   <= 1'b0;
      held_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      wraps_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      dir_q   <= dir_d;
      held_q  <= held_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      wraps_q <= wraps_d;
    end
  end

  assign bus.DIR   = dir_q;
  assign bus.LOCK  = lock_q;
  assign bus.HELD  = held_q;
  assign bus.ERR   = err_q;
  assign bus.WRAPS = wraps_q;

endmodule
